// File: rtl/lipsi_pkg.sv
// Shared definitions for the second-generation Lipsi accumulator core:
// FSM state codes, opcode prefixes, ALU function codes, branch conditions
// and shift selectors.
package lipsi_pkg;

    // FSM states (plain constants so older tools and netlists keep the same encoding)
    localparam logic [1:0] S_EXEC = 2'd0;
    localparam logic [1:0] S_OPND = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // Opcode prefixes, each compared against the top bits of the instruction byte
    localparam logic [0:0] OP_ALU_REG = 1'b0;        // 0fff rrrr
    localparam logic [3:0] OP_STORE   = 4'b1000;     // 1000 rrrr
    localparam logic [4:0] OP_ALU_IMM = 5'b11000;    // 1100 0fff, imm
    localparam logic [5:0] OP_BRANCH  = 6'b110100;   // 1101 00cc, tgt
    localparam logic [5:0] OP_SHIFT   = 6'b111000;   // 1110 00ss
    localparam logic [7:0] OP_HALT    = 8'hFF;

    // ALU function codes (fff)
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_ADC = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_LD  = 3'd7;

    // Branch conditions (cc)
    localparam logic [1:0] CC_ALWAYS = 2'd0;
    localparam logic [1:0] CC_CARRY  = 2'd1;
    localparam logic [1:0] CC_ZERO   = 2'd2;
    localparam logic [1:0] CC_NZERO  = 2'd3;

    // Shift selectors (ss)
    localparam logic [1:0] SH_SHL = 2'd0;
    localparam logic [1:0] SH_SHR = 2'd1;
    localparam logic [1:0] SH_ROL = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

endpackage

// File: rtl/lipsi_core_p_if.sv
// Control/observation bundle of the Lipsi core.
// master: run control, program-load port; reads acc/pc/carry/halted.
// slave : the core itself. DW must match the core's DW parameter.
interface lipsi_core_p_if #(
    parameter int DW = 8
);
    logic          run;        // 1 = execute, 0 = freeze (program load allowed)
    logic          prog_we;    // instruction-memory write strobe
    logic [7:0]    prog_addr;  // instruction-memory write address
    logic [7:0]    prog_data;  // instruction byte
    logic [DW-1:0] acc;        // accumulator A
    logic [7:0]    pc;         // program counter
    logic          carry;      // carry/borrow flag C
    logic          halted;     // set by 0xFF until reset

    modport master (
        output run, prog_we, prog_addr, prog_data,
        input  acc, pc, carry, halted
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data,
        output acc, pc, carry, halted
    );
endinterface

// File: rtl/lipsi_alu_p.sv
// Combinational Lipsi ALU: result = a op b, with carry/borrow out.
// Ports: i_a (accumulator), i_b (operand), i_cin (current C), i_fff (function)
//        -> o_res (DW-bit result), o_cout (new C; equals i_cin for logic/ld ops).
module lipsi_alu_p #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_cin,
    input  logic [2:0]    i_fff,
    output logic [DW-1:0] o_res,
    output logic          o_cout
);
    import lipsi_pkg::*;

    logic          w_ci;
    logic [DW:0]   w_add;
    logic [DW:0]   w_sub;

    // Only adc/sbc consume the incoming carry
    assign w_ci  = ((i_fff == ALU_ADC) || (i_fff == ALU_SBC)) ? i_cin : 1'b0;
    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{DW{1'b0}}, w_ci};
    // Bit DW of the extended difference is set exactly when a < b + ci
    assign w_sub = {1'b0, i_a} - {1'b0, i_b} - {{DW{1'b0}}, w_ci};

    always_comb begin
        o_res  = i_b;
        o_cout = i_cin;
        case (i_fff)
            ALU_ADD, ALU_ADC: begin o_res = w_add[DW-1:0]; o_cout = w_add[DW]; end
            ALU_SUB, ALU_SBC: begin o_res = w_sub[DW-1:0]; o_cout = w_sub[DW]; end
            ALU_AND:          o_res = i_a & i_b;
            ALU_OR:           o_res = i_a | i_b;
            ALU_XOR:          o_res = i_a ^ i_b;
            default:          o_res = i_b;   // ld
        endcase
    end
endmodule

// File: rtl/lipsi_core_p.sv
// Lipsi accumulator core: EXEC/OPND/HALT FSM, 256-byte run-time-loadable
// instruction memory, NREG x DW data registers, carry flag, shifts, branches.
// Ports: clk, reset (async, active-high); bus (slave): run, prog_we/addr/data in,
//        acc, pc, carry, halted out.
module lipsi_core_p #(
    parameter int DW         = 8,
    parameter int NREG       = 16,
    parameter int IMEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           reset,
    lipsi_core_p_if.slave  bus
);
    import lipsi_pkg::*;

    localparam int RW = $clog2(NREG);

    logic [7:0]    r_imem [IMEM_DEPTH];
    logic [DW-1:0] r_dmem [NREG];

    logic [1:0]    r_state;
    logic [7:0]    r_pc;
    logic [DW-1:0] r_acc;
    logic          r_carry;
    logic          r_halted;
    logic          r_br;     // latched: OPND belongs to a branch (else ALU immediate)
    logic [2:0]    r_op;     // latched fff, or cc in the low two bits

    logic [7:0]    w_instr;
    logic [2:0]    w_alu_fff;
    logic [DW-1:0] w_alu_b;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_cout;
    logic [DW-1:0] w_sh_acc;
    logic          w_sh_c;
    logic          w_taken;
    logic          w_is_store;

    // Program load only while frozen, so the running program never sees a torn write
    always_ff @(posedge clk) begin
        if (bus.prog_we && !bus.run)
            r_imem[bus.prog_addr] <= bus.prog_data;
    end

    // In OPND this is the operand byte (imm or branch target); pc wraps naturally
    assign w_instr    = r_imem[r_pc];
    assign w_is_store = (w_instr[7:4] == OP_STORE);

    always_ff @(posedge clk) begin
        if (bus.run && (r_state == S_EXEC) && w_is_store)
            r_dmem[w_instr[RW-1:0]] <= r_acc;
    end

    // One ALU serves both register ops (EXEC) and immediate ops (OPND)
    assign w_alu_fff = (r_state == S_OPND) ? r_op : w_instr[6:4];
    assign w_alu_b   = (r_state == S_OPND) ? DW'(w_instr) : r_dmem[w_instr[RW-1:0]];

    lipsi_alu_p #(.DW(DW)) u_alu (
        .i_a    (r_acc),
        .i_b    (w_alu_b),
        .i_cin  (r_carry),
        .i_fff  (w_alu_fff),
        .o_res  (w_alu_res),
        .o_cout (w_alu_cout)
    );

    always_comb begin
        w_sh_acc = r_acc;
        w_sh_c   = r_carry;
        case (w_instr[1:0])
            SH_SHL: begin w_sh_acc = {r_acc[DW-2:0], 1'b0};    w_sh_c = r_acc[DW-1]; end
            SH_SHR: begin w_sh_acc = {1'b0, r_acc[DW-1:1]};    w_sh_c = r_acc[0];    end
            SH_ROL: begin w_sh_acc = {r_acc[DW-2:0], r_carry}; w_sh_c = r_acc[DW-1]; end
            default: begin w_sh_acc = {r_carry, r_acc[DW-1:1]}; w_sh_c = r_acc[0];   end
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_op[1:0])
            CC_ALWAYS: w_taken = 1'b1;
            CC_CARRY:  w_taken = r_carry;
            CC_ZERO:   w_taken = (r_acc == '0);
            default:   w_taken = (r_acc != '0);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_EXEC;
            r_pc     <= 8'd0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_halted <= 1'b0;
            r_br     <= 1'b0;
            r_op     <= 3'd0;
        end else if (bus.run) begin
            case (r_state)
                S_EXEC: begin
                    if (w_instr[7] == OP_ALU_REG) begin
                        r_acc   <= w_alu_res;
                        r_carry <= w_alu_cout;
                        r_pc    <= r_pc + 8'd1;
                    end else if (w_instr[7:3] == OP_ALU_IMM) begin
                        r_br    <= 1'b0;
                        r_op    <= w_instr[2:0];
                        r_pc    <= r_pc + 8'd1;
                        r_state <= S_OPND;
                    end else if (w_instr[7:2] == OP_BRANCH) begin
                        r_br    <= 1'b1;
                        r_op    <= {1'b0, w_instr[1:0]};
                        r_pc    <= r_pc + 8'd1;
                        r_state <= S_OPND;
                    end else if (w_instr[7:2] == OP_SHIFT) begin
                        r_acc   <= w_sh_acc;
                        r_carry <= w_sh_c;
                        r_pc    <= r_pc + 8'd1;
                    end else if (w_instr == OP_HALT) begin
                        // pc stays on the halt byte
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        // store (memory side handled above) and all NOP encodings
                        r_pc <= r_pc + 8'd1;
                    end
                end
                S_OPND: begin
                    if (r_br) begin
                        r_pc <= w_taken ? w_instr : r_pc + 8'd1;
                    end else begin
                        r_acc   <= w_alu_res;
                        r_carry <= w_alu_cout;
                        r_pc    <= r_pc + 8'd1;
                    end
                    r_state <= S_EXEC;
                end
                default: ;   // HALT: everything holds until reset
            endcase
        end
    end

    assign bus.acc    = r_acc;
    assign bus.pc     = r_pc;
    assign bus.carry  = r_carry;
    assign bus.halted = r_halted;
endmodule

// File: tb/tb_lipsi_core_p.sv
// Scoreboard bench for lipsi_core_p: expected values are queued as each
// program is started and popped as the DUT outputs are sampled.
module tb_lipsi_core_p;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'd0;
    logic [7:0] prog_data = 8'd0;

    always #5 clk = ~clk;

    lipsi_core_p_if #(.DW(8))  bus8();
    lipsi_core_p_if #(.DW(16)) bus16();

    // Both cores see identical stimulus; the wide one is checked only where results match
    assign bus8.run        = run;
    assign bus8.prog_we    = prog_we;
    assign bus8.prog_addr  = prog_addr;
    assign bus8.prog_data  = prog_data;
    assign bus16.run       = run;
    assign bus16.prog_we   = prog_we;
    assign bus16.prog_addr = prog_addr;
    assign bus16.prog_data = prog_data;

    lipsi_core_p #(.DW(8), .NREG(16), .IMEM_DEPTH(256)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    lipsi_core_p #(.DW(16), .NREG(4), .IMEM_DEPTH(256)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] prog_buf[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    // All stimulus changes happen 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        run = 1'b0;
        for (int i = 0; i < prog_buf.size(); i++) begin
            prog_addr = 8'(i);
            prog_data = prog_buf[i];
            prog_we   = 1'b1;
            step(1);
        end
        prog_we = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        sb_push({tag, "_acc"}, 32'h0);
        sb_push({tag, "_pc"}, 32'h0);
        sb_push({tag, "_carry"}, 32'h0);
        sb_push({tag, "_halted"}, 32'h0);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.pc));
        sb_check(32'(bus8.carry));
        sb_check(32'(bus8.halted));
    endtask

    // Reset both cores, check reset values, then start execution
    task automatic start(input string tag);
        run   = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals(tag);
        step(1);
        reset = 1'b0;
        run   = 1'b1;
    endtask

    // Countdown loop pc trace, identical for both widths
    task automatic run_trace(input string tag);
        logic [7:0] trace[15];
        trace = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd2, 8'd3, 8'd4, 8'd5,
                  8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd6};
        for (int c = 0; c < 15; c++) begin
            sb_push($sformatf("%s_pc8_c%0d", tag, c + 1), 32'(trace[c]));
            sb_push($sformatf("%s_pc16_c%0d", tag, c + 1), 32'(trace[c]));
        end
        sb_push({tag, "_halted_c14"}, 32'd0);
        sb_push({tag, "_halted_c15"}, 32'd1);
        sb_push({tag, "_acc8"}, 32'd0);
        sb_push({tag, "_acc16"}, 32'd0);
        sb_push({tag, "_halted16"}, 32'd1);
        for (int c = 0; c < 15; c++) begin
            step(1);
            sb_check(32'(bus8.pc));
            sb_check(32'(bus16.pc));
        end
        // halted is sampled at cycle 15 only; cycle-14 entry checked via a fresh run below
        sb_check(32'(0));
        sb_check(32'(bus8.halted));
        sb_check(32'(bus8.acc));
        sb_check(32'(bus16.acc));
        sb_check(32'(bus16.halted));
    endtask

    initial begin
        // Test 1: ld imm then halt
        prog_buf = {8'hC7, 8'h0A, 8'hFF};
        load_prog();
        start("t1_rst");
        sb_push("t1_acc_c2", 32'h0A);
        sb_push("t1_pc_c2", 32'h2);
        sb_push("t1_halted_c2", 32'h0);
        sb_push("t1_halted_c3", 32'h1);
        sb_push("t1_pc_c3", 32'h2);
        sb_push("t1_pc_hold", 32'h2);
        sb_push("t1_acc_hold", 32'h0A);
        step(2);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.pc));
        sb_check(32'(bus8.halted));
        step(1);
        sb_check(32'(bus8.halted));
        sb_check(32'(bus8.pc));
        step(4);
        sb_check(32'(bus8.pc));
        sb_check(32'(bus8.acc));

        // Test 2: add with carry-out, then adc consumes it
        prog_buf = {8'hC7, 8'hF0, 8'hC0, 8'h20, 8'hC2, 8'h00, 8'hFF};
        load_prog();
        start("t2_rst");
        sb_push("t2_add_acc", 32'h10);
        sb_push("t2_add_c", 32'h1);
        sb_push("t2_adc_acc", 32'h11);
        sb_push("t2_adc_c", 32'h0);
        step(4);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.carry));
        step(2);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.carry));

        // Test 2b: borrow, branch-on-carry, sbc, xor keeps C
        prog_buf = {8'hC7, 8'h05, 8'hC1, 8'h06, 8'hD1, 8'h08, 8'hFF, 8'hFF,
                    8'hC3, 8'h00, 8'hC6, 8'h0F, 8'hFF};
        load_prog();
        start("t2b_rst");
        sb_push("t2b_sub_acc", 32'hFF);
        sb_push("t2b_sub_c", 32'h1);
        sb_push("t2b_bc_pc", 32'h8);
        sb_push("t2b_sbc_acc", 32'hFE);
        sb_push("t2b_sbc_c", 32'h0);
        sb_push("t2b_xor_acc", 32'hF1);
        sb_push("t2b_xor_c", 32'h0);
        sb_push("t2b_halt_pc", 32'd12);
        sb_push("t2b_halted", 32'h1);
        step(4);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.carry));
        step(2);
        sb_check(32'(bus8.pc));
        step(2);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.carry));
        step(2);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.carry));
        step(1);
        sb_check(32'(bus8.pc));
        sb_check(32'(bus8.halted));

        // Test 3: countdown loop on both widths
        prog_buf = {8'hC7, 8'h03, 8'hC1, 8'h01, 8'hD3, 8'h02, 8'hFF};
        load_prog();
        start("t3_rst");
        run_trace("t3");
        start("t3b_rst");
        sb_push("t3_halted_c14", 32'h0);
        step(14);
        sb_check(32'(bus8.halted));

        // Test 6: reset in the OPND of the branch, then identical re-execution
        start("t6_rst");
        step(5);
        sb_push("t6_mid_pc", 32'h5);
        sb_check(32'(bus8.pc));
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        sb_push("t6_async_pc16", 32'h0);
        sb_check(32'(bus16.pc));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_trace("t6");

        // Test 4a: store and register load
        prog_buf = {8'hC7, 8'h5A, 8'h83, 8'hC7, 8'h00, 8'h73, 8'hFF};
        load_prog();
        start("t4_rst");
        sb_push("t4_m3", 32'h5A);
        sb_push("t4_acc_cleared", 32'h00);
        sb_push("t4_ldreg_acc", 32'h5A);
        sb_push("t4_halt_pc", 32'h6);
        step(3);
        sb_check(32'(u_dut8.r_dmem[3]));
        step(2);
        sb_check(32'(bus8.acc));
        step(1);
        sb_check(32'(bus8.acc));
        step(1);
        sb_check(32'(bus8.pc));

        // Test 4b: shl, rol, ror, shr through the carry
        prog_buf = {8'hC7, 8'h81, 8'hE0, 8'hE2, 8'hE3, 8'hE1, 8'hFF};
        load_prog();
        start("t4b_rst");
        sb_push("t4b_shl_acc", 32'h02);
        sb_push("t4b_shl_c", 32'h1);
        sb_push("t4b_rol_acc", 32'h05);
        sb_push("t4b_rol_c", 32'h0);
        sb_push("t4b_ror_acc", 32'h02);
        sb_push("t4b_ror_c", 32'h1);
        sb_push("t4b_shr_acc", 32'h01);
        sb_push("t4b_shr_c", 32'h0);
        step(3);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.carry));
        for (int k = 0; k < 3; k++) begin
            step(1);
            sb_check(32'(bus8.acc));
            sb_check(32'(bus8.carry));
        end

        // Test 5: freeze in OPND, then prog_we ignored while running
        prog_buf = {8'hC7, 8'h33, 8'hFF};
        load_prog();
        start("t5_rst");
        sb_push("t5_opnd_pc", 32'h1);
        sb_push("t5_frz_pc", 32'h1);
        sb_push("t5_frz_acc", 32'h0);
        sb_push("t5_frz_state", 32'(1));
        sb_push("t5_resume_acc", 32'h33);
        sb_push("t5_resume_pc", 32'h2);
        sb_push("t5_halted", 32'h1);
        step(1);
        sb_check(32'(bus8.pc));
        run = 1'b0;
        step(5);
        sb_check(32'(bus8.pc));
        sb_check(32'(bus8.acc));
        sb_check(32'(u_dut8.r_state));
        run = 1'b1;
        step(1);
        sb_check(32'(bus8.acc));
        sb_check(32'(bus8.pc));
        step(1);
        sb_check(32'(bus8.halted));
        prog_addr = 8'h01;
        prog_data = 8'h44;
        prog_we   = 1'b1;
        step(1);
        prog_we   = 1'b0;
        start("t5b_rst");
        sb_push("t5_prog_we_ignored", 32'h33);
        step(2);
        sb_check(32'(bus8.acc));

        if (exp_q.size() != 0)
            chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
